// File: rtl/result_acc_pkg.sv
// Shared types and default widths for the result accumulator slice.
package result_acc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int unsigned CNT_W      = 4;
    localparam int unsigned DEF_SUM_W  = 9;
    localparam int unsigned DEF_PROD_W = 16;
    localparam int unsigned DEF_ACC_W  = 24;

endpackage

// File: rtl/result_accumulator_if.sv
// Input beat stream and output summary channel of the result accumulator.
interface result_accumulator_if
    import result_acc_pkg::*;
#(
    parameter int unsigned SUM_W  = DEF_SUM_W,
    parameter int unsigned PROD_W = DEF_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [SUM_W-1:0]  in_sum;
    logic [PROD_W-1:0] in_prod;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum_acc;
    logic [ACC_W-1:0]  out_prod_acc;
    logic [CNT_W-1:0]  out_count;
    logic              out_sat;
    logic [PROD_W-1:0] out_prod_max;

    modport master (
        output in_valid, in_sum, in_prod, out_ready,
        input  in_ready, out_valid, out_sum_acc, out_prod_acc,
               out_count, out_sat, out_prod_max
    );

    modport slave (
        input  in_valid, in_sum, in_prod, out_ready,
        output in_ready, out_valid, out_sum_acc, out_prod_acc,
               out_count, out_sat, out_prod_max
    );

endinterface

// File: rtl/result_accumulator_sat_add.sv
// Saturating adder: zero-extends the operand and clamps to all-ones on carry.
module sat_add #(
    parameter int unsigned W  = 24,
    parameter int unsigned OW = 16
) (
    input  logic [W-1:0]  acc,
    input  logic [OW-1:0] opnd,
    output logic [W-1:0]  result,
    output logic          overflow
);

    logic [W:0] wide;

    assign wide     = {1'b0, acc} + (W+1)'(opnd);
    assign overflow = wide[W];
    assign result   = wide[W] ? '1 : wide[W-1:0];

endmodule

// File: rtl/result_accumulator.sv
// Batches {sum, product} beats into one held summary record per BATCH beats.
// Optional product-max tracking is built when RESULT_ACC_MINMAX_EN is defined.
module result_accumulator
    import result_acc_pkg::*;
#(
    parameter int unsigned SUM_W  = DEF_SUM_W,
    parameter int unsigned PROD_W = DEF_PROD_W,
    parameter int unsigned ACC_W  = DEF_ACC_W,
    parameter int unsigned BATCH  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    result_accumulator_if.slave  bus
);

    state_t           state, state_nxt;
    logic [ACC_W-1:0] sum_acc, prod_acc, sum_nxt, prod_nxt;
    logic [CNT_W-1:0] count;
    logic             sat, sum_ovf, prod_ovf;
    logic             accept, emit, last_beat;

    assign bus.in_ready  = (state == ACCUM);
    assign bus.out_valid = (state == HOLD);
    assign accept        = bus.in_ready && bus.in_valid;
    assign emit          = bus.out_valid && bus.out_ready;
    assign last_beat     = (count == CNT_W'(BATCH - 1));

    sat_add #(.W(ACC_W), .OW(SUM_W)) u_sum_add (
        .acc      (sum_acc),
        .opnd     (bus.in_sum),
        .result   (sum_nxt),
        .overflow (sum_ovf)
    );

    sat_add #(.W(ACC_W), .OW(PROD_W)) u_prod_add (
        .acc      (prod_acc),
        .opnd     (bus.in_prod),
        .result   (prod_nxt),
        .overflow (prod_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCUM;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACCUM:   if (accept && last_beat) state_nxt = HOLD;
            HOLD:    if (emit) state_nxt = ACCUM;
            default: state_nxt = ACCUM;
        endcase
        // clear wins over any same-cycle beat or summary handoff
        if (clear) state_nxt = ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_acc  <= '0;
            prod_acc <= '0;
            count    <= '0;
            sat      <= 1'b0;
        end else if (clear || emit) begin
            sum_acc  <= '0;
            prod_acc <= '0;
            count    <= '0;
            sat      <= 1'b0;
        end else if (accept) begin
            sum_acc  <= sum_nxt;
            prod_acc <= prod_nxt;
            count    <= count + 1'b1;
            sat      <= sat | sum_ovf | prod_ovf;
        end
    end

`ifdef RESULT_ACC_MINMAX_EN
    logic [PROD_W-1:0] prod_max;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            prod_max <= '0;
        else if (clear || emit)
            prod_max <= '0;
        else if (accept && (bus.in_prod > prod_max))
            prod_max <= bus.in_prod;
    end

    assign bus.out_prod_max = prod_max;
`else
    assign bus.out_prod_max = '0;
`endif

    assign bus.out_sum_acc  = sum_acc;
    assign bus.out_prod_acc = prod_acc;
    assign bus.out_count    = count;
    assign bus.out_sat      = sat;

endmodule

// File: tb/tb_result_accumulator.sv
// Directed self-checking bench for result_accumulator (24-bit/BATCH=4 and 16-bit/BATCH=2 builds).
module tb_result_accumulator;

`ifdef RESULT_ACC_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic clk, rst_n, clear;
    int   n_chk  = 0;
    int   n_pass = 0;

    result_accumulator_if #(.SUM_W(9), .PROD_W(16), .ACC_W(24)) ba ();
    result_accumulator_if #(.SUM_W(9), .PROD_W(16), .ACC_W(16)) bb ();

    result_accumulator #(.SUM_W(9), .PROD_W(16), .ACC_W(24), .BATCH(4)) u_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (ba.slave)
    );

    result_accumulator #(.SUM_W(9), .PROD_W(16), .ACC_W(16), .BATCH(2)) u_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mx(input logic [31:0] v);
        return MM ? v : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic put_a(input logic [8:0] s, input logic [15:0] p);
        int n = 0;
        ba.in_valid = 1'b1;
        ba.in_sum   = s;
        ba.in_prod  = p;
        while (!ba.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("a_ready_timeout", 32'(ba.in_ready), 1);
        @(posedge clk);
        #1 ba.in_valid = 1'b0;
    endtask

    task automatic put_b(input logic [8:0] s, input logic [15:0] p);
        int n = 0;
        bb.in_valid = 1'b1;
        bb.in_sum   = s;
        bb.in_prod  = p;
        while (!bb.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("b_ready_timeout", 32'(bb.in_ready), 1);
        @(posedge clk);
        #1 bb.in_valid = 1'b0;
    endtask

    task automatic basic_stream();
        put_a(9'd109, 16'd990);
        put_a(9'd43,  16'd330);
        put_a(9'd165, 16'd4356);
        put_a(9'd136, 16'd528);
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_in_ready"},  32'(ba.in_ready), 1);
        chk({pfx, "_out_valid"}, 32'(ba.out_valid), 0);
        chk({pfx, "_sum"},       32'(ba.out_sum_acc), 0);
        chk({pfx, "_prod"},      32'(ba.out_prod_acc), 0);
        chk({pfx, "_count"},     32'(ba.out_count), 0);
        chk({pfx, "_sat"},       32'(ba.out_sat), 0);
        chk({pfx, "_max"},       32'(ba.out_prod_max), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        ba.in_valid = 1'b0; ba.in_sum = '0; ba.in_prod = '0; ba.out_ready = 1'b1;
        bb.in_valid = 1'b0; bb.in_sum = '0; bb.in_prod = '0; bb.out_ready = 1'b1;

        #12;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // basic batch, downstream always ready
        basic_stream();
        @(negedge clk);
        chk("basic_valid",    32'(ba.out_valid), 1);
        chk("basic_in_ready", 32'(ba.in_ready), 0);
        chk("basic_sum",      32'(ba.out_sum_acc), 453);
        chk("basic_prod",     32'(ba.out_prod_acc), 6204);
        chk("basic_count",    32'(ba.out_count), 4);
        chk("basic_sat",      32'(ba.out_sat), 0);
        chk("basic_max",      32'(ba.out_prod_max), mx(4356));
        @(negedge clk);
        chk("basic_after_valid", 32'(ba.out_valid), 0);
        chk("basic_after_ready", 32'(ba.in_ready), 1);

        // backpressure with a stray beat offered during HOLD
        ba.out_ready = 1'b0;
        basic_stream();
        ba.in_valid = 1'b1; ba.in_sum = 9'd7; ba.in_prod = 16'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid",    32'(ba.out_valid), 1);
            chk("bp_in_ready", 32'(ba.in_ready), 0);
            chk("bp_sum",      32'(ba.out_sum_acc), 453);
            chk("bp_prod",     32'(ba.out_prod_acc), 6204);
        end
        ba.out_ready = 1'b1;
        ba.in_valid  = 1'b0;
        @(negedge clk);
        chk("bp_release_ready", 32'(ba.in_ready), 1);
        chk("bp_release_valid", 32'(ba.out_valid), 0);
        chk("bp_release_sum",   32'(ba.out_sum_acc), 0);

        // clear coincident with a third beat drops it
        ba.out_ready = 1'b0;
        put_a(9'd50, 16'd60);
        put_a(9'd50, 16'd60);
        ba.in_valid = 1'b1; ba.in_sum = 9'd9; ba.in_prod = 16'd9;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        ba.in_valid = 1'b0;
        @(negedge clk);
        chk("clr_count", 32'(ba.out_count), 0);
        chk("clr_sum",   32'(ba.out_sum_acc), 0);
        chk("clr_ready", 32'(ba.in_ready), 1);
        for (int i = 0; i < 4; i++) put_a(9'd1, 16'd1);
        @(negedge clk);
        chk("clr_fresh_valid", 32'(ba.out_valid), 1);
        chk("clr_fresh_sum",   32'(ba.out_sum_acc), 4);
        chk("clr_fresh_prod",  32'(ba.out_prod_acc), 4);
        chk("clr_fresh_count", 32'(ba.out_count), 4);
        chk("clr_fresh_max",   32'(ba.out_prod_max), mx(1));
        // clear beats a same-cycle summary handoff
        ba.out_ready = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("clr_hold_valid", 32'(ba.out_valid), 0);
        chk("clr_hold_sum",   32'(ba.out_sum_acc), 0);

        // asynchronous reset while in HOLD
        ba.out_ready = 1'b0;
        basic_stream();
        @(negedge clk);
        chk("rst_hold_valid", 32'(ba.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("rst_async");
        @(negedge clk);
        rst_n = 1'b1;
        ba.out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_post_valid", 32'(ba.out_valid), 0);
        end

        // gapped input matches the gap-free totals
        put_a(9'd109, 16'd990);
        @(posedge clk); #1;
        put_a(9'd43, 16'd330);
        @(posedge clk); #1;
        put_a(9'd165, 16'd4356);
        @(posedge clk); #1;
        put_a(9'd136, 16'd528);
        @(negedge clk);
        chk("gap_valid", 32'(ba.out_valid), 1);
        chk("gap_sum",   32'(ba.out_sum_acc), 453);
        chk("gap_prod",  32'(ba.out_prod_acc), 6204);
        chk("gap_count", 32'(ba.out_count), 4);

        // saturation on the 16-bit, BATCH=2 build
        put_b(9'd1, 16'd65025);
        put_b(9'd1, 16'd65025);
        @(negedge clk);
        chk("sat_valid", 32'(bb.out_valid), 1);
        chk("sat_prod",  32'(bb.out_prod_acc), 65535);
        chk("sat_flag",  32'(bb.out_sat), 1);
        chk("sat_sum",   32'(bb.out_sum_acc), 2);
        chk("sat_count", 32'(bb.out_count), 2);
        chk("sat_max",   32'(bb.out_prod_max), mx(65025));
        @(negedge clk);
        chk("sat_emitted", 32'(bb.out_valid), 0);
        put_b(9'd3, 16'd100);
        put_b(9'd4, 16'd200);
        @(negedge clk);
        chk("sat_next_valid", 32'(bb.out_valid), 1);
        chk("sat_next_prod",  32'(bb.out_prod_acc), 300);
        chk("sat_next_flag",  32'(bb.out_sat), 0);
        chk("sat_next_sum",   32'(bb.out_sum_acc), 7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/result_accumulator.md
# result_accumulator

Downstream consumer of the adder/multiplier stage. Accepts a stream of `{sum, product}` result pairs over a valid/ready handshake. Accumulates both fields over a fixed-size batch and emits one summary record per batch. Summary fields are the sum total, the product total, the beat count and a sticky saturation flag. The summary is held until the downstream side accepts it.

## Interface
Parameters:
- `SUM_W`, default 9: width of incoming sum.
- `PROD_W`, default 16: width of incoming product.
- `ACC_W`, default 24: width of both accumulators; must be ≥ `PROD_W`.
- `BATCH`, default 4: beats per summary, range 1..15.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `clear`, input, 1: synchronous abort; discards the partial batch.
- `in_valid`, input, 1: input beat present.
- `in_ready`, output, 1: block can accept a beat.
- `in_sum`, input, `SUM_W`: sum operand of the beat.
- `in_prod`, input, `PROD_W`: product operand of the beat.
- `out_valid`, output, 1: summary present.
- `out_ready`, input, 1: downstream accepts the summary.
- `out_sum_acc`, output, `ACC_W`: accumulated sums.
- `out_prod_acc`, output, `ACC_W`: accumulated products.
- `out_count`, output, 4: beats in this summary; always `BATCH`.
- `out_sat`, output, 1: saturation occurred in this batch.
- `out_prod_max`, output, `PROD_W`: largest product in the batch (see Configuration).

## Operation
- FSM states are `ACCUM` and `HOLD`; the reset state is `ACCUM`.
- **ACCUM state**
  - `in_ready`=1 and `out_valid`=0.
  - A beat is accepted when `in_valid && in_ready`.
  - On acceptance: `sum_acc += zero-extend(in_sum)`, `prod_acc += zero-extend(in_prod)`, `count += 1`.
  - When the accepted beat makes `count == BATCH`, go to `HOLD` on the next edge.
- **HOLD state**
  - `in_ready`=0 and `out_valid`=1.
  - Outputs are stable until `out_valid && out_ready`.
  - On acceptance: accumulators, `count` and `sat` are zeroed, and the FSM returns to `ACCUM`.
- **Saturation:** each add is computed at `ACC_W+1` bits. If the carry is set, the accumulator takes the value `2^ACC_W-1` and `sat` is set. `sat` is sticky until the batch is emitted or cleared.
- **`clear` handling**
  - `clear`=1 at an edge zeroes accumulators, `count` and `sat`, and forces `ACCUM`.
  - `clear` has priority over a same-cycle input accept: that beat is dropped.
  - `clear` also has priority over a same-cycle output accept: the summary is dropped.
- **Output wiring:** `out_*` data ports are driven directly from the accumulator registers. In `ACCUM` they show partial values; these are don't-care while `out_valid`=0.
- **Reset values:** `in_ready`=1, `out_valid`=0, `out_sum_acc`=0, `out_prod_acc`=0, `out_count`=0, `out_sat`=0, `out_prod_max`=0.

## Timing
- `in_ready` and `out_valid` are registered-state decodes, with no combinational path from `in_valid` or `out_ready`.
- Latency: `out_valid` rises on the edge that accepts beat `BATCH`, i.e. the cycle after that beat is presented.
- Peak throughput is `BATCH` beats per `BATCH`+1 cycles when `out_ready` is held high. One bubble is spent in `HOLD`.
- Back-to-back: the cycle after summary acceptance, `in_ready`=1 again.
- `BATCH`=1: every accepted beat produces a summary. The FSM alternates `ACCUM` and `HOLD`.
- `rst_n` asserted mid-batch or in `HOLD`: immediate return to reset values with no summary emitted. Release is synchronised externally.

## Configuration
- **`RESULT_ACC_MINMAX_EN` defined:** a `PROD_W`-bit max register is updated on each accepted beat when `in_prod > max`. It is zeroed with the accumulators and driven on `out_prod_max`.
- **Not defined:** no register is built, and `out_prod_max` is tied to 0. The port list is unchanged.

## Structure
- **Package `result_acc_pkg`:**
  - state enum `{ACCUM, HOLD}`;
  - `CNT_W`=4;
  - default width constants `SUM_W`, `PROD_W` and `ACC_W`.
- **Sub-module `sat_add`:** parameterised on width. It zero-extends its operand and adds with saturation, outputting `{result, overflow}`. It is instantiated twice, once for the sum accumulator and once for the product accumulator.

## Test plan
- **Basic batch:** `BATCH`=4, beats (109,990), (43,330), (165,4356), (136,528), `out_ready`=1. Expect one summary: `out_sum_acc`=453, `out_prod_acc`=6204, `out_count`=4, `out_sat`=0. With the macro defined, also expect `out_prod_max`=4356.
- **Backpressure:** same stream with `out_ready`=0 for 3 cycles after `out_valid`. Outputs must be stable and `in_ready`=0 throughout. On the first cycle with `out_ready`=1 the summary is taken, and `in_ready`=1 on the next cycle.
- **Saturation:** `ACC_W`=16, `BATCH`=2, two beats with prod=65025. Expect `out_prod_acc`=65535, `out_sat`=1. The next batch shows `out_sat`=0.
- **Clear:** 2 beats accepted, then `clear`=1 coincident with a valid third beat. The third beat is dropped. Four fresh beats (1,1) yield `out_sum_acc`=4 and `out_prod_acc`=4.
- **Reset mid-operation:** assert `rst_n`=0 in `HOLD`. All outputs must show reset values asynchronously, and no summary is accepted after release.
- **Gapped input:** `in_valid` toggled every other cycle. Counts and accumulators must match the gap-free stream.
